// File: rtl/reset_pkg.sv
// Shared types and constants for the global reset generator.
// Cause bits are ordered {sw, wdt, btn, lock, por} to match the firmware view.
package reset_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STRETCH   = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam int CAUSE_W    = 5;
    localparam int CAUSE_POR  = 0;
    localparam int CAUSE_LOCK = 1;
    localparam int CAUSE_BTN  = 2;
    localparam int CAUSE_WDT  = 3;
    localparam int CAUSE_SW   = 4;

    function automatic logic [CAUSE_W-1:0] cause_mask(input int idx);
        logic [CAUSE_W-1:0] m;
        m = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes a raw bouncy button and only accepts a new level after it has
// stayed put for DEBOUNCE_CYCLES cycles; also flags the debounced press edge.
module btn_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_btn_stable,
    output logic o_btn_evt
);

    localparam int              DEB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DEB_W-1:0]       r_cnt;
    logic                   r_stable;
    logic                   r_evt;

    logic w_btn_s;
    logic w_differ;
    logic w_done;

    assign w_btn_s  = r_sync[SYNC_STAGES-1];
    assign w_differ = w_btn_s ^ r_stable;
    assign w_done   = w_differ && (r_cnt == DEB_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync   <= '0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_evt    <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
            // Any return to the accepted level restarts the stability window.
            if (!w_differ || w_done) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DEB_W'(1);
            end
            if (w_done) begin
                r_stable <= w_btn_s;
            end
            r_evt <= w_done & w_btn_s;
        end
    end

    assign o_btn_stable = r_stable;
    assign o_btn_evt    = r_evt;

endmodule

// File: rtl/reset_gen.sv
// Merges POR, PLL lock, button, watchdog and software requests into one
// stretched clk-synchronous global reset, plus a sticky reset-cause record.
module reset_gen
    import reset_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int STRETCH_CYCLES  = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_pll_locked,
    input  logic               i_btn_rst,
    input  logic               i_wdt_bite,
    input  logic               i_sw_rst_req,
    input  logic               i_rst_cause_clr,
    output logic               o_rst_globl,
    output logic [CAUSE_W-1:0] o_rst_cause
);

    localparam int               STR_W    = $clog2(STRETCH_CYCLES);
    localparam logic [STR_W-1:0] STR_LAST = STR_W'(STRETCH_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_lock_sync;
    state_t                 r_state;
    logic [STR_W-1:0]       r_cnt;
    logic                   r_rst_globl;
    logic [CAUSE_W-1:0]     r_cause;

    state_t             w_state_nxt;
    logic [STR_W-1:0]   w_cnt_nxt;
    logic               w_rst_nxt;
    logic [CAUSE_W-1:0] w_cause_set;
    logic               w_lock_s;
    logic               w_btn_stable;
    logic               w_btn_evt;
    logic               w_trig;
    logic               w_lock_loss;

    btn_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_btn        (i_btn_rst),
        .o_btn_stable (w_btn_stable),
        .o_btn_evt    (w_btn_evt)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lock_sync <= '0;
        end else begin
            r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], i_pll_locked};
        end
    end

    assign w_lock_s = r_lock_sync[SYNC_STAGES-1];
    assign w_trig   = w_btn_evt | i_wdt_bite | i_sw_rst_req;
    // Outside WAIT_LOCK lock_s was high last cycle, so a low here is the falling edge.
    assign w_lock_loss = ~w_lock_s & (r_state != WAIT_LOCK);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= WAIT_LOCK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_nxt = STRETCH;
                end
            end
            STRETCH: begin
                if (!w_lock_s) begin
                    w_state_nxt = WAIT_LOCK;
                end else if (!w_trig && !w_btn_stable && (r_cnt == STR_LAST)) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (!w_lock_s) begin
                    w_state_nxt = WAIT_LOCK;
                end else if (w_trig) begin
                    w_state_nxt = STRETCH;
                end
            end
            default: begin
                w_state_nxt = WAIT_LOCK;
            end
        endcase
    end

    // Counter only advances on an undisturbed STRETCH cycle; everything else parks it at 0.
    always_comb begin
        w_cnt_nxt = '0;
        w_rst_nxt = (w_state_nxt != RUN);
        if ((r_state == STRETCH) && w_lock_s && !w_trig && !w_btn_stable &&
            (r_cnt != STR_LAST)) begin
            w_cnt_nxt = r_cnt + STR_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt       <= '0;
            r_rst_globl <= 1'b1;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_rst_globl <= w_rst_nxt;
        end
    end

    always_comb begin
        w_cause_set = '0;
        if (w_lock_loss) begin
            w_cause_set = w_cause_set | cause_mask(CAUSE_LOCK);
        end
        if (w_btn_evt) begin
            w_cause_set = w_cause_set | cause_mask(CAUSE_BTN);
        end
        if (i_wdt_bite) begin
            w_cause_set = w_cause_set | cause_mask(CAUSE_WDT);
        end
        if (i_sw_rst_req) begin
            w_cause_set = w_cause_set | cause_mask(CAUSE_SW);
        end
    end

    // A clear in the same cycle as an event keeps exactly that event's bits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cause <= cause_mask(CAUSE_POR);
        end else if (i_rst_cause_clr) begin
            r_cause <= w_cause_set;
        end else begin
            r_cause <= r_cause | w_cause_set;
        end
    end

    assign o_rst_globl = r_rst_globl;
    assign o_rst_cause = r_cause;

endmodule

// File: tb/tb_reset_gen.sv
// Bench for reset_gen with SYNC_STAGES=2, DEBOUNCE_CYCLES=8, STRETCH_CYCLES=4.
module tb_reset_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll, btn, wdt, sw, clr;
    logic       rg;
    logic [4:0] cause;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       pll;
        logic       btn;
        logic       wdt;
        logic       sw;
        logic       clr;
        logic       rg;
        logic [4:0] cause;
        string      tag;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    reset_gen #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (8),
        .STRETCH_CYCLES  (4)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_pll_locked    (pll),
        .i_btn_rst       (btn),
        .i_wdt_bite      (wdt),
        .i_sw_rst_req    (sw),
        .i_rst_cause_clr (clr),
        .o_rst_globl     (rg),
        .o_rst_cause     (cause)
    );

    function automatic vec_t mk(input logic p, b, w, s, c, r, input logic [4:0] ca,
                                input string t);
        vec_t v;
        v.pll = p; v.btn = b; v.wdt = w; v.sw = s; v.clr = c;
        v.rg = r; v.cause = ca; v.tag = t;
        return v;
    endfunction

    task automatic check(input string nm, input logic [4:0] act, input logic [4:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", nm, act, req);
        end
    endtask

    // Drive one cycle of stimulus at negedge, compare registered outputs after the posedge.
    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        pll = v.pll; btn = v.btn; wdt = v.wdt; sw = v.sw; clr = v.clr;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        wdt = 1'b0; sw = 1'b0; clr = 1'b0;
        e = exp_q.pop_front();
        check({e.tag, ".rst_globl"}, {4'b0, rg}, {4'b0, e.rg});
        check({e.tag, ".rst_cause"}, cause, e.cause);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, got running, expected done");
        $fatal(1);
    end

    initial begin
        // Power-up: lock arrives, then exactly 6 high rows (2 sync + 4 stretch).
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0,0,0,0,0, 1, 5'b00001, $sformatf("pwr_nolock%0d", i)));
        for (int i = 0; i < 6; i++) tbl.push_back(mk(1,0,0,0,0, 1, 5'b00001, $sformatf("pwr_stretch%0d", i)));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,0,0,0, 0, 5'b00001, $sformatf("pwr_run%0d", i)));
        // Watchdog after clear.
        tbl.push_back(mk(1,0,0,0,1, 0, 5'b00000, "wdt_clr"));
        tbl.push_back(mk(1,0,1,0,0, 1, 5'b01000, "wdt_bite"));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,0,0,0, 1, 5'b01000, $sformatf("wdt_str%0d", i)));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(1,0,0,0,0, 0, 5'b01000, $sformatf("wdt_run%0d", i)));
        // Software request, lock dropped so lock_s is low while cnt==2.
        tbl.push_back(mk(1,0,0,1,1, 1, 5'b10000, "lk_sw"));
        tbl.push_back(mk(0,0,0,0,0, 1, 5'b10000, "lk_drop0"));
        tbl.push_back(mk(0,0,0,0,0, 1, 5'b10000, "lk_drop1"));
        tbl.push_back(mk(0,0,0,0,0, 1, 5'b10010, "lk_drop2"));
        tbl.push_back(mk(0,0,0,0,0, 1, 5'b10010, "lk_drop3"));
        for (int i = 0; i < 6; i++) tbl.push_back(mk(1,0,0,0,0, 1, 5'b10010, $sformatf("lk_relock%0d", i)));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(1,0,0,0,0, 0, 5'b10010, $sformatf("lk_run%0d", i)));
        // Simultaneous sw, wdt and clear.
        tbl.push_back(mk(1,0,1,1,1, 1, 5'b11000, "sim_all"));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,0,0,0, 1, 5'b11000, $sformatf("sim_str%0d", i)));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(1,0,0,0,0, 0, 5'b11000, $sformatf("sim_run%0d", i)));
        // Second trigger mid-stretch restarts the count.
        tbl.push_back(mk(1,0,0,0,1, 0, 5'b00000, "rs_clr"));
        tbl.push_back(mk(1,0,1,0,0, 1, 5'b01000, "rs_wdt0"));
        tbl.push_back(mk(1,0,0,0,0, 1, 5'b01000, "rs_cnt1"));
        tbl.push_back(mk(1,0,1,0,0, 1, 5'b01000, "rs_wdt1"));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,0,0,0, 1, 5'b01000, $sformatf("rs_str%0d", i)));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(1,0,0,0,0, 0, 5'b01000, $sformatf("rs_run%0d", i)));

        rst_n = 1'b0;
        pll = 1'b0; btn = 1'b0; wdt = 1'b0; sw = 1'b0; clr = 1'b0;
        for (int i = 0; i < 5; i++) apply(mk(0,0,0,0,0, 1, 5'b00001, $sformatf("por%0d", i)));
        rst_n = 1'b1;

        foreach (tbl[i]) apply(tbl[i]);

        // Button: bounce every 3 cycles, hold from row 18 to 31, release at 32.
        for (int i = 0; i < 48; i++) begin
            logic b;
            logic r;
            b = (i < 20) ? (((i / 3) % 2) == 0) : (i < 32);
            r = (i >= 28) && (i <= 44);
            apply(mk(1, b, 0, 0, (i == 0), r, (i >= 28) ? 5'b00100 : 5'b00000,
                     $sformatf("btn%0d", i)));
        end

        // Async reset between clock edges while in STRETCH.
        apply(mk(1,0,0,1,1, 1, 5'b10000, "as_sw"));
        apply(mk(1,0,0,0,0, 1, 5'b10000, "as_str"));
        #2 rst_n = 1'b0;
        #1;
        check("as_mid_stretch.rst_globl", {4'b0, rg}, 5'b00001);
        check("as_mid_stretch.rst_cause", cause, 5'b00001);
        for (int i = 0; i < 2; i++) apply(mk(1,0,0,0,0, 1, 5'b00001, $sformatf("as_hold%0d", i)));
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) apply(mk(1,0,0,0,0, 1, 5'b00001, $sformatf("as_rel%0d", i)));
        for (int i = 0; i < 2; i++) apply(mk(1,0,0,0,0, 0, 5'b00001, $sformatf("as_run%0d", i)));

        // Async reset while running must raise rst_globl without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("as_in_run.rst_globl", {4'b0, rg}, 5'b00001);
        apply(mk(1,0,0,0,0, 1, 5'b00001, "as_run_hold"));
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
